nibble_serial_adder: RTL and testbench

Multi-cycle wide adder/subtractor built around the existing combinational `four_bit_adder`. It accepts a wide operand pair over a valid/ready handshake and feeds the adder one nibble per clock, least-significant first. The nibble carry is held in a register between cycles, and each nibble sum is assembled into a result register. The block sits directly upstream of `four_bit_adder`, driving its `op_a`, `op_b` and `carry_in` and consuming its `sum` and `carry_out`. It presents a streaming interface to the rest of the design.

---
 rtl/adder_pkg.sv | 14 +
 rtl/four_bit_adder.sv | 27 ++
 rtl/nibble_serial_adder.sv | 97 +++++++++
 tb/tb_nibble_serial_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder and its nibble datapath.
package adder_pkg;

    // Width of one adder slice.
    localparam int NIBBLE_W = 4;

    // Control states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

endpackage : adder_pkg

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple-carry adder slice used by the serial adder.
module four_bit_adder
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] op_a,
    input  logic [NIBBLE_W-1:0] op_b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carry_out
);

    logic [NIBBLE_W:0] carry_chain;

    // Bit-level ripple: each stage produces its sum bit and the carry into the next stage.
    always_comb begin
        carry_chain    = '0;
        sum            = '0;
        carry_chain[0] = carry_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]           = op_a[i] ^ op_b[i] ^ carry_chain[i];
            carry_chain[i+1] = (op_a[i] & op_b[i]) | (carry_chain[i] & (op_a[i] ^ op_b[i]));
        end
    end

    assign carry_out = carry_chain[NIBBLE_W];

endmodule : four_bit_adder

// File: rtl/nibble_serial_adder.sv
// Wide adder/subtractor that streams one nibble per clock through a four_bit_adder,
// least-significant nibble first, with the inter-nibble carry held in a register.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                        in_carry,
    input  logic                        in_sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_carry
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    nsa_state_t          state;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        sum_q;
    logic                c_q;
    logic [IDX_W-1:0]    idx;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_carry;

    // Subtraction is A + ~B + 1, so the operand inversion and forced carry happen at accept time.
    assign nib_a = a_q[NIBBLE_W*int'(idx) +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*int'(idx) +: NIBBLE_W];

    four_bit_adder u_adder (
        .op_a      (nib_a),
        .op_b      (nib_b),
        .carry_in  (c_q),
        .sum       (nib_sum),
        .carry_out (nib_carry)
    );

    // Control FSM plus operand, carry, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_sub ? ~in_b : in_b;
                        c_q   <= in_sub ? 1'b1 : in_carry;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[NIBBLE_W*int'(idx) +: NIBBLE_W] <= nib_sum;
                    c_q <= nib_carry;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags and result are decoded purely from registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = out_valid ? sum_q : '0;
    assign out_carry = out_valid & c_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_carry;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_carry;

    int checks;
    int errors;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_carry  (in_carry),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offers one operand pair once the block is ready; returns just after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_carry = cin;
        in_sub   = sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic waitResult(output int latency);
        latency = 0;
        do begin
            @(posedge clk);
            latency++;
            @(negedge clk);
        end while (!out_valid && latency < 20);
    endtask

    // Consumes the result with a one-cycle out_ready pulse and checks the return to IDLE.
    task automatic releaseResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    // Full transaction: accept, latency, result and release.
    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] exp_sum, input logic exp_carry);
        int lat;
        applyStimulus(a, b, cin, sub);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        checkOutput({tag, "_carry"}, 32'(out_carry), 32'(exp_carry));
        releaseResult(tag);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_sum;
        logic         held_carry;
        logic         saw_valid;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_carry  = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("rst_out_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain adds, full ripple, subtracts with in_carry ignored, all-ones add.
        runOp("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        runOp("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        runOp("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        runOp("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        runOp("add_ffff_cin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

        // Back-pressure in DONE with a new pair pending on the input.
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd4);
        checkOutput("bp_sum", 32'(out_sum), 32'h0100);
        checkOutput("bp_carry", 32'(out_carry), 32'd0);
        held_sum   = out_sum;
        held_carry = out_carry;
        in_valid = 1'b1;
        in_a     = 16'h8000;
        in_b     = 16'h8000;
        in_carry = 1'b0;
        in_sub   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_sum", 32'(out_sum), 32'(held_sum));
            checkOutput("bp_hold_carry", 32'(out_carry), 32'(held_carry));
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(lat);
        checkOutput("bp_next_latency", 32'(lat), 32'd4);
        checkOutput("bp_next_sum", 32'(out_sum), 32'h0000);
        checkOutput("bp_next_carry", 32'(out_carry), 32'd1);
        releaseResult("bp_next");

        // Asynchronous reset two clocks into RUN.
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rstrun_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rstrun_out_sum", 32'(out_sum), 32'd0);
        checkOutput("rstrun_out_carry", 32'(out_carry), 32'd0);
        checkOutput("rstrun_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("rstrun_no_valid", 32'(saw_valid), 32'd0);
        runOp("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

        // Asynchronous reset while a result is held in DONE.
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("rstdone_sum_before", 32'(out_sum), 32'h8000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstdone_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rstdone_out_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("after_rst2", 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_nibble_serial_adder
